// File: rtl/detector_jogada.sv
// Debounces the answer keys, latches the accepted key code and emits a one-cycle
// fez_jogada pulse; re-arms only after the keys have been fully released.
module detector_jogada #(
   parameter int unsigned N_CHAVES        = 4,
   parameter int unsigned DEBOUNCE_CICLOS = 1000
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                habilita,
   input  logic                limpa,
   input  logic [N_CHAVES-1:0] chaves,
   output logic                fez_jogada,
   output logic [N_CHAVES-1:0] jogada,
   output logic                jogada_invalida,
   output logic [2:0]          db_estado
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

   localparam logic [2:0] OCIOSO        = 3'd0;
   localparam logic [2:0] ESTABILIZA    = 3'd1;
   localparam logic [2:0] PULSO         = 3'd2;
   localparam logic [2:0] ESPERA_SOLTAR = 3'd3;

   logic [2:0]          estado_q, estado_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N_CHAVES-1:0] amostra_q, amostra_d;
   logic [N_CHAVES-1:0] jogada_q, jogada_d;
   logic                invalida_q, invalida_d;
   logic                fez_q, fez_d;
   logic                um_bit;

   // Exactly one key pressed: nonzero and a power of two.
   assign um_bit = (amostra_q != '0) &&
                   ((amostra_q & (amostra_q - N_CHAVES'(1))) == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q   <= OCIOSO;
         cnt_q      <= '0;
         amostra_q  <= '0;
         jogada_q   <= '0;
         invalida_q <= 1'b0;
         fez_q      <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         cnt_q      <= cnt_d;
         amostra_q  <= amostra_d;
         jogada_q   <= jogada_d;
         invalida_q <= invalida_d;
         fez_q      <= fez_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      cnt_d      = cnt_q;
      amostra_d  = amostra_q;
      jogada_d   = jogada_q;
      invalida_d = invalida_q;

      case (estado_q)
         OCIOSO: begin
            if (habilita && (chaves != '0)) begin
               amostra_d = chaves;
               cnt_d     = '0;
               estado_d  = ESTABILIZA;
            end
         end
         ESTABILIZA: begin
            // Any bounce, key-set change or loss of habilita abandons the press.
            if (!habilita || (chaves != amostra_q)) begin
               estado_d = OCIOSO;
            end else if (cnt_q == CNT_MAX) begin
               jogada_d   = amostra_q;
               invalida_d = !um_bit;
               estado_d   = PULSO;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PULSO: begin
            cnt_d    = '0;
            estado_d = ESPERA_SOLTAR;
         end
         ESPERA_SOLTAR: begin
            if (chaves != '0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               estado_d = OCIOSO;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase

      // Clear wins over a latch in the same cycle.
      if (limpa) begin
         jogada_d   = '0;
         invalida_d = 1'b0;
      end

      fez_d = (estado_d == PULSO);
   end

   assign fez_jogada      = fez_q;
   assign jogada          = jogada_q;
   assign jogada_invalida = invalida_q;
   assign db_estado       = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: directed scenarios plus random key
// activity, checked cycle by cycle against an edge-indexed reference model.
module tb_detector_jogada;

   localparam int unsigned N = 4;
   localparam int D = 4;

   logic         clock;
   logic         reset_n;
   logic         habilita;
   logic         limpa;
   logic [N-1:0] chaves;
   logic         fez_jogada;
   logic [N-1:0] jogada;
   logic         jogada_invalida;
   logic [2:0]   db_estado;

   typedef struct packed {
      logic         fez;
      logic [N-1:0] jog;
      logic         inv;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: edge index bookkeeping instead of a state machine.
   int           m_n     = 0;   // index of the upcoming clock edge
   int           m_start = -1;  // edge at which the current candidate press was sampled
   logic [N-1:0] m_val   = '0;  // key set of the candidate press
   int           m_rel   = -1;  // first edge where release is observed, -1 when armed
   int           m_zero  = 0;   // consecutive all-released edges seen
   logic [N-1:0] m_jog   = '0;
   logic         m_inv   = 1'b0;

   detector_jogada #(.N_CHAVES(N), .DEBOUNCE_CICLOS(D)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .habilita       (habilita),
      .limpa          (limpa),
      .chaves         (chaves),
      .fez_jogada     (fez_jogada),
      .jogada         (jogada),
      .jogada_invalida(jogada_invalida),
      .db_estado      (db_estado)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic int ones(input logic [N-1:0] v);
      int n = 0;
      for (int i = 0; i < int'(N); i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Predict the outputs visible after the next rising edge.
   task automatic model_edge(input logic h, input logic l, input logic [N-1:0] c);
      exp_t e;
      e.fez = 1'b0;
      if (m_rel >= 0) begin
         if (m_n >= m_rel) begin
            if (c == '0) m_zero++;
            else m_zero = 0;
            if (m_zero == D) m_rel = -1;
         end
      end else if (m_start < 0) begin
         if (h && (c != '0)) begin
            m_start = m_n;
            m_val   = c;
         end
      end else if (!h || (c != m_val)) begin
         m_start = -1;
      end else if (m_n - m_start == D) begin
         e.fez   = 1'b1;
         m_jog   = m_val;
         m_inv   = (ones(m_val) != 1);
         m_rel   = m_n + 2;
         m_zero  = 0;
         m_start = -1;
      end
      if (l) begin
         m_jog = '0;
         m_inv = 1'b0;
      end
      e.jog = m_jog;
      e.inv = m_inv;
      exp_q.push_back(e);
      m_n++;
   endtask

   task automatic step(input logic h, input logic l, input logic [N-1:0] c);
      @(negedge clock);
      reset_n  = 1'b1;
      habilita = h;
      limpa    = l;
      chaves   = c;
      model_edge(h, l, c);
   endtask

   task automatic do_reset();
      exp_t e;
      @(negedge clock);
      reset_n  = 1'b0;
      habilita = 1'b0;
      limpa    = 1'b0;
      chaves   = '0;
      #1;
      check("rst_fez", int'(fez_jogada), 0);
      check("rst_jogada", int'(jogada), 0);
      check("rst_invalida", int'(jogada_invalida), 0);
      check("rst_estado", int'(db_estado), 0);
      m_start = -1;
      m_rel   = -1;
      m_zero  = 0;
      m_jog   = '0;
      m_inv   = 1'b0;
      e       = '0;
      exp_q.push_back(e);
      m_n++;
   endtask

   // Monitor: one expected entry per rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fez_jogada", int'(fez_jogada), int'(e.fez));
            check("jogada", int'(jogada), int'(e.jog));
            check("jogada_invalida", int'(jogada_invalida), int'(e.inv));
         end
      end
   end

   initial begin
      logic [N-1:0] v;
      logic         h;
      int           len;
      reset_n  = 1'b0;
      habilita = 1'b0;
      limpa    = 1'b0;
      chaves   = '0;

      do_reset();

      // Single clean press held well past the debounce window.
      repeat (12) step(1'b1, 1'b0, 4'b0010);
      repeat (5)  step(1'b1, 1'b0, 4'b0000);

      // Bouncing key, then a stable hold.
      for (int i = 0; i < 10; i++)
         repeat (2) step(1'b1, 1'b0, (i % 2 == 0) ? 4'b0010 : 4'b0000);
      repeat (8) step(1'b1, 1'b0, 4'b0010);
      repeat (5) step(1'b1, 1'b0, 4'b0000);

      // Two keys together, then clear.
      repeat (8) step(1'b1, 1'b0, 4'b0101);
      step(1'b1, 1'b0, 4'b0000);
      step(1'b1, 1'b1, 4'b0000);
      repeat (4) step(1'b1, 1'b0, 4'b0000);

      // Presses ignored while habilita is low.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 4'b1000);
         check("estado_desabilitado", int'(db_estado), 0);
      end
      repeat (8) step(1'b1, 1'b0, 4'b1000);
      repeat (5) step(1'b1, 1'b0, 4'b0000);

      // Re-arm needs a full release.
      repeat (6) step(1'b1, 1'b0, 4'b0001);
      repeat (2) step(1'b1, 1'b0, 4'b0000);
      repeat (3) step(1'b1, 1'b0, 4'b0001);
      repeat (5) step(1'b1, 1'b0, 4'b0000);
      repeat (8) step(1'b1, 1'b0, 4'b0001);
      repeat (5) step(1'b1, 1'b0, 4'b0000);

      // Key set change mid-debounce restarts from the new value.
      repeat (2) step(1'b1, 1'b0, 4'b0010);
      repeat (7) step(1'b1, 1'b0, 4'b0110);
      repeat (5) step(1'b1, 1'b0, 4'b0000);

      // Reset in the middle of a debounce.
      repeat (3) step(1'b1, 1'b0, 4'b0100);
      do_reset();
      repeat (7) step(1'b1, 1'b0, 4'b0100);
      repeat (5) step(1'b1, 1'b0, 4'b0000);

      // Random key activity.
      for (int s = 0; s < 300; s++) begin
         if ($urandom_range(0, 99) < 3) begin
            do_reset();
         end else begin
            h = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 3))
               0:       v = '0;
               1, 2:    v = 4'b0001 << $urandom_range(0, 3);
               default: v = 4'($urandom_range(0, 15));
            endcase
            len = int'($urandom_range(1, 8));
            repeat (len) step(h, ($urandom_range(0, 19) == 0), v);
         end
      end

      repeat (2) @(negedge clock);
      check("scoreboard_vazio", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
